// File: rtl/wb_unit_mp.sv
//------------------------------------------------------------------------------
// Module      : wb_unit_mp
// Description : Writeback stage with one register-file write port shared by
//               two sources. Main-pipeline results (ALU or aligned and
//               extended load data) always win the port. Long-latency
//               (mul/div) results are queued in a small FIFO and drain into
//               idle writeback slots. A starvation counter requests a
//               pipeline bubble when the FIFO head has waited too long.
//               Optional macro WB_LL_BYPASS_EN lets a long-latency result
//               skip the empty FIFO for single-cycle latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wb_unit_mp #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8,
  localparam int OFF_W     = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  // main pipeline
  input  logic              RegWrite_in,
  input  logic              MemToReg,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [OFF_W-1:0]  ByteOffset,
  input  logic [REG_AW-1:0] DestReg_in,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] MemRead_data,
  // long-latency producer
  input  logic              LL_valid,
  output logic              LL_ready,
  input  logic [REG_AW-1:0] LL_dest,
  input  logic [DATA_W-1:0] LL_data,
  // register-file write port
  output logic              RegWrite_out,
  output logic [REG_AW-1:0] DestReg_out,
  output logic [DATA_W-1:0] RegWrite_data,
  output logic              Stall_req
);

  localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] c_FULL       = CNT_W'(LL_DEPTH);
  localparam logic [STV_W-1:0] c_STARVE_MAX = STV_W'(STARVE_MAX);
  // Clearing bit 0 of the byte offset gives the byte address of the halfword.
  localparam logic [OFF_W-1:0] c_HALF_MASK  = ~OFF_W'(1);

  //--------------------------------------------------------------------------
  // Load alignment and extension
  //--------------------------------------------------------------------------
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_main_data;

  // Shifting right (instead of a variable part-select) keeps every offset
  // in range even when DATA_W is not a multiple of 16.
  assign w_byte = 8'(MemRead_data >> {ByteOffset, 3'b000});
  assign w_half = 16'(MemRead_data >> {ByteOffset & c_HALF_MASK, 3'b000});

  // Pick the load width and extend it to the datapath width.
  always_comb begin
    w_load = MemRead_data;
    case (MemSize)
      2'b00:   w_load = {{(DATA_W-8){MemSigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(DATA_W-16){MemSigned & w_half[15]}}, w_half};
      default: w_load = MemRead_data;
    endcase
  end

  assign w_main_data = MemToReg ? w_load : ALU_result;

  //--------------------------------------------------------------------------
  // Long-latency FIFO control
  //--------------------------------------------------------------------------
  logic [REG_AW-1:0] r_fifo_dest [LL_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [LL_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;

  logic              w_full;
  logic              w_empty;
  logic              w_main_wr;
  logic              w_pop;
  logic              w_push;
  logic              w_bypass;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [STV_W-1:0]  w_starve_nxt;
  logic              w_stall_nxt;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  // A write to register 0 is discarded and leaves the slot idle.
  assign w_main_wr = RegWrite_in && (DestReg_in != '0);
  assign w_pop     = !w_empty && !w_main_wr;
  // Ready is held low through reset so nothing is accepted and then flushed.
  assign LL_ready  = !rst && !w_full;

`ifdef WB_LL_BYPASS_EN
  assign w_bypass = w_empty && !w_main_wr && LL_valid && (LL_dest != '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Results for register 0 are acknowledged but never stored.
  assign w_push = LL_valid && LL_ready && (LL_dest != '0) && !w_bypass;

  // Occupancy and starvation bookkeeping for the next cycle.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    // Non-empty without a pop can only mean a main write took the port.
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != c_STARVE_MAX) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end

    w_stall_nxt = (w_starve_nxt == c_STARVE_MAX) && (w_count_nxt != '0);
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dest[r_wr_ptr] <= LL_dest;
      r_fifo_data[r_wr_ptr] <= LL_data;
    end
  end

  // Pointers, occupancy, starvation counter and bubble request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      Stall_req <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_nxt;
      r_starve  <= w_starve_nxt;
      Stall_req <= w_stall_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Write port arbitration: main > FIFO head > bypass
  //--------------------------------------------------------------------------
  // Register the winning write; address and data hold when the slot is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_out  <= 1'b0;
      DestReg_out   <= '0;
      RegWrite_data <= '0;
    end else if (w_main_wr) begin
      RegWrite_out  <= 1'b1;
      DestReg_out   <= DestReg_in;
      RegWrite_data <= w_main_data;
    end else if (w_pop) begin
      RegWrite_out  <= 1'b1;
      DestReg_out   <= r_fifo_dest[r_rd_ptr];
      RegWrite_data <= r_fifo_data[r_rd_ptr];
    end else if (w_bypass) begin
      RegWrite_out  <= 1'b1;
      DestReg_out   <= LL_dest;
      RegWrite_data <= LL_data;
    end else begin
      RegWrite_out  <= 1'b0;
    end
  end

endmodule

`default_nettype wire
